// File: rtl/mul_accumulator.sv
// Frame-based multiply-accumulate back end: sums a stream of 2n-bit products up to a last
// marker and holds the total on a valid/ready port. Define MUL_ACC_SATURATE_EN to clamp on overflow.
module mul_accumulator #(
    parameter int N     = 8,
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               up_valid_i,
    output logic               up_ready_o,
    input  logic [2*N-1:0]     up_res_i,
    input  logic               up_signed_i,
    input  logic               up_last_i,
    output logic               down_valid_o,
    input  logic               down_ready_i,
    output logic [ACC_W-1:0]   down_acc_o,
    output logic [CNT_W-1:0]   down_count_o,
    output logic               down_signed_o,
    output logic               down_ovf_o
);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    localparam logic [ACC_W-1:0] SMAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SMIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               mode_q, mode_d;
    logic               ovf_q, ovf_d;

    logic               accept;
    logic               mode_sel;
    logic [ACC_W-1:0]   ext;
    logic [ACC_W:0]     sum;
    logic               step_ovf;
    logic [ACC_W-1:0]   acc_step;

    assign up_ready_o = (state_q != HOLD);
    assign accept     = up_valid_i && up_ready_o;

    // The first beat of a frame fixes the mode; later beats reuse the stored one.
    assign mode_sel = (state_q == IDLE) ? up_signed_i : mode_q;
    assign ext      = mode_sel ? ACC_W'($signed(up_res_i)) : ACC_W'(up_res_i);
    assign sum      = {1'b0, acc_q} + {1'b0, ext};

    always_comb begin
        step_ovf = 1'b0;
        if (mode_q)
            step_ovf = (acc_q[ACC_W-1] == ext[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);
        else
            step_ovf = sum[ACC_W];
    end

    always_comb begin
        acc_step = sum[ACC_W-1:0];
`ifdef MUL_ACC_SATURATE_EN
        // Signed overflow can only occur with like-signed operands, so ext's sign picks the bound.
        if (step_ovf)
            acc_step = mode_q ? (ext[ACC_W-1] ? SMIN : SMAX) : {ACC_W{1'b1}};
`endif
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    mode_d  = up_signed_i;
                    acc_d   = ext;
                    cnt_d   = CNT_W'(1);
                    ovf_d   = 1'b0;
                    state_d = up_last_i ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    acc_d = acc_step;
                    cnt_d = cnt_q + CNT_W'(1);
                    ovf_d = ovf_q | step_ovf;
                    if (up_last_i)
                        state_d = HOLD;
                end
            end
            HOLD: begin
                if (down_ready_i) begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                    mode_d  = 1'b0;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            ovf_q   <= ovf_d;
        end
    end

    // Outputs read zero outside HOLD so partial sums never leak onto the port.
    assign down_valid_o  = (state_q == HOLD);
    assign down_acc_o    = down_valid_o ? acc_q : '0;
    assign down_count_o  = down_valid_o ? cnt_q : '0;
    assign down_signed_o = down_valid_o & mode_q;
    assign down_ovf_o    = down_valid_o & ovf_q;

endmodule

// File: tb/tb_mul_accumulator.sv
// Directed bench for mul_accumulator: a 24-bit and a 16-bit accumulator share one stimulus stream.
module tb_mul_accumulator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        up_valid = 1'b0;
    logic [15:0] up_res = '0;
    logic        up_signed = 1'b0;
    logic        up_last = 1'b0;
    logic        down_ready = 1'b0;

    logic        a_up_ready, a_down_valid, a_down_signed, a_down_ovf;
    logic [23:0] a_down_acc;
    logic [7:0]  a_down_count;
    logic        b_up_ready, b_down_valid, b_down_signed, b_down_ovf;
    logic [15:0] b_down_acc;
    logic [7:0]  b_down_count;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mul_accumulator #(.N(8), .ACC_W(24), .CNT_W(8)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .up_valid_i(up_valid), .up_ready_o(a_up_ready), .up_res_i(up_res),
        .up_signed_i(up_signed), .up_last_i(up_last),
        .down_valid_o(a_down_valid), .down_ready_i(down_ready),
        .down_acc_o(a_down_acc), .down_count_o(a_down_count),
        .down_signed_o(a_down_signed), .down_ovf_o(a_down_ovf)
    );

    mul_accumulator #(.N(8), .ACC_W(16), .CNT_W(8)) dut16 (
        .clk_i(clk), .rst_ni(rst_n),
        .up_valid_i(up_valid), .up_ready_o(b_up_ready), .up_res_i(up_res),
        .up_signed_i(up_signed), .up_last_i(up_last),
        .down_valid_o(b_down_valid), .down_ready_i(down_ready),
        .down_acc_o(b_down_acc), .down_count_o(b_down_count),
        .down_signed_o(b_down_signed), .down_ovf_o(b_down_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [15:0] res, input logic sgn, input logic last);
        @(negedge clk);
        up_valid  = 1'b1;
        up_res    = res;
        up_signed = sgn;
        up_last   = last;
        @(posedge clk);
        #1;
        up_valid = 1'b0;
        up_last  = 1'b0;
        $display("beat res=%h signed=%0b last=%0b", res, sgn, last);
    endtask

    task automatic take(input string tag);
        @(negedge clk);
        down_ready = 1'b1;
        @(posedge clk);
        #1;
        down_ready = 1'b0;
        chk({tag, "_ready_after"}, {31'b0, a_up_ready}, 32'd1);
        chk({tag, "_valid_after"}, {31'b0, a_down_valid}, 32'd0);
    endtask

    task automatic chk_a(input string tag, input logic [23:0] acc, input logic [7:0] cnt,
                         input logic sgn, input logic ovf);
        $display("result %s acc=%h count=%0d signed=%0b ovf=%0b", tag, a_down_acc,
                 a_down_count, a_down_signed, a_down_ovf);
        chk({tag, "_valid"}, {31'b0, a_down_valid}, 32'd1);
        chk({tag, "_upready"}, {31'b0, a_up_ready}, 32'd0);
        chk({tag, "_acc"}, {8'b0, a_down_acc}, {8'b0, acc});
        chk({tag, "_count"}, {24'b0, a_down_count}, {24'b0, cnt});
        chk({tag, "_signed"}, {31'b0, a_down_signed}, {31'b0, sgn});
        chk({tag, "_ovf"}, {31'b0, a_down_ovf}, {31'b0, ovf});
    endtask

    initial begin
        logic [15:0] exp16;
        // Reset state, including up_ready while reset is held.
        #2;
        chk("rst_upready", {31'b0, a_up_ready}, 32'd1);
        chk("rst_valid", {31'b0, a_down_valid}, 32'd0);
        chk("rst_acc", {8'b0, a_down_acc}, 32'd0);
        chk("rst_count", {24'b0, a_down_count}, 32'd0);
        chk("rst_ovf", {31'b0, a_down_ovf}, 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // Signed frame: -6 + 20 = 14.
        beat(16'hFFFA, 1'b1, 1'b0);
        chk("sig_midvalid", {31'b0, a_down_valid}, 32'd0);
        beat(16'h0014, 1'b1, 1'b1);
        chk_a("sig", 24'h00000E, 8'd2, 1'b1, 1'b0);
        take("sig");

        // Unsigned frame with up_signed flipped on the second beat.
        beat(16'hFFFA, 1'b0, 1'b0);
        beat(16'h0014, 1'b1, 1'b1);
        chk_a("uns", 24'h01000E, 8'd2, 1'b0, 1'b0);
        take("uns");

        // Unsigned overflow on the 16-bit instance, then 5 cycles of backpressure.
        beat(16'hFFFF, 1'b0, 1'b0);
        beat(16'h0002, 1'b0, 1'b1);
        chk_a("u24", 24'h010001, 8'd2, 1'b0, 1'b0);
`ifdef MUL_ACC_SATURATE_EN
        exp16 = 16'hFFFF;
`else
        exp16 = 16'h0001;
`endif
        chk("u16_acc", {16'b0, b_down_acc}, {16'b0, exp16});
        chk("u16_ovf", {31'b0, b_down_ovf}, 32'd1);
        @(negedge clk);
        up_valid = 1'b1; up_res = 16'h1234; up_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            $display("hold cycle %0d valid=%0b up_ready=%0b acc=%h", i, a_down_valid, a_up_ready, a_down_acc);
            chk("bp_upready", {31'b0, a_up_ready}, 32'd0);
            chk("bp_acc", {8'b0, a_down_acc}, 32'h010001);
            chk("bp_count", {24'b0, a_down_count}, 32'd2);
        end
        up_valid = 1'b0; up_last = 1'b0;
        take("bp");

        // Signed overflow on the 16-bit instance, continuing after the overflow.
        beat(16'h7FFF, 1'b1, 1'b0);
        beat(16'h0001, 1'b1, 1'b0);
        beat(16'hFFFF, 1'b1, 1'b1);
        chk_a("s24", 24'h007FFF, 8'd3, 1'b1, 1'b0);
`ifdef MUL_ACC_SATURATE_EN
        exp16 = 16'h7FFE;
`else
        exp16 = 16'h7FFF;
`endif
        chk("s16_acc", {16'b0, b_down_acc}, {16'b0, exp16});
        chk("s16_ovf", {31'b0, b_down_ovf}, 32'd1);
        take("s16");

        // Single-beat signed frame; count restarts at 1.
        beat(16'h8000, 1'b1, 1'b1);
        chk_a("single", 24'hFF8000, 8'd1, 1'b1, 1'b0);
        take("single");

        // down_ready held high: result visible for exactly one cycle.
        down_ready = 1'b1;
        beat(16'h0005, 1'b0, 1'b1);
        chk("dr_valid", {31'b0, a_down_valid}, 32'd1);
        chk("dr_acc", {8'b0, a_down_acc}, 32'h5);
        @(posedge clk);
        #1;
        chk("dr_valid_next", {31'b0, a_down_valid}, 32'd0);
        chk("dr_upready_next", {31'b0, a_up_ready}, 32'd1);
        down_ready = 1'b0;

        // Reset mid-frame discards the partial sum.
        beat(16'h0100, 1'b0, 1'b0);
        beat(16'h0200, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mrst_upready", {31'b0, a_up_ready}, 32'd1);
        chk("mrst_valid", {31'b0, a_down_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        beat(16'h0003, 1'b0, 1'b1);
        chk_a("mrst", 24'h000003, 8'd1, 1'b0, 1'b0);
        take("mrst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
